// File: rtl/cdc_send_pacer.sv
// -----------------------------------------------------------------------------
// cdc_send_pacer
//
// Send-domain pacing stage placed directly in front of a pulse-based
// clock-domain crossing. Incoming bytes are buffered in a small FIFO and
// re-emitted one at a time as single-cycle launch pulses. Consecutive pulses
// are always separated by at least GAP idle cycles, so the receive-side pulse
// synchroniser never sees two pulses it cannot resolve. Bytes that arrive
// while the buffer is full are discarded and flagged on a sticky overflow bit.
//
// Parameters
//   DATA_W   byte width
//   DEPTH    FIFO entries (power of two, >= 2)
//   GAP      minimum idle cycles between valid_o pulses (1..255)
//
// Ports
//   clk_i       in   send-domain clock (only clock)
//   resetn_i    in   asynchronous active-low reset
//   data_i      in   byte from the producer
//   valid_i     in   byte present, sampled on rising clk_i
//   ready_o     out  buffer not full (combinational from the level)
//   clr_i       in   single-cycle pulse clearing overflow_o
//   data_o      out  registered byte toward the CDC stage
//   valid_o     out  registered single-cycle launch pulse
//   level_o     out  current FIFO occupancy, 0..DEPTH
//   overflow_o  out  sticky flag: a byte was dropped on a full buffer
// -----------------------------------------------------------------------------
module cdc_send_pacer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int GAP    = 4
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       clr_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and bookkeeping registers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_overflow;

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // ---------------------------------------------------------------------------
  // Combinational handshake decode
  // ---------------------------------------------------------------------------
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;

  // Fullness is judged on the level before the edge, so a byte offered to a
  // full buffer is dropped even if the pacer pops an entry at that same edge.
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = valid_i && !w_full;
  assign w_drop  = valid_i &&  w_full;
  // The only place an entry leaves the buffer is a launch from IDLE.
  assign w_pop   = (r_state == ST_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rptr];

  // ---------------------------------------------------------------------------
  // FIFO storage: plain array, written at the tail. No reset is needed on the
  // contents because the pointers and level define what is valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy. Pointers are AW bits and wrap modulo DEPTH on
  // their own since DEPTH is a power of two; the extra level bit
  // distinguishes full from empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky overflow. A drop at the same edge as a clear wins, so a byte lost
  // right as software acknowledges the previous loss is never hidden.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_i) begin
      r_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pacing FSM.
  //   IDLE: launch the head byte as soon as one is queued, load the gap
  //         counter with GAP.
  //   GAP : count down; the edge that sees cnt==1 returns to IDLE, so the
  //         earliest next launch is GAP+1 edges after the previous one and
  //         exactly GAP cycles with valid_o low lie between pulses.
  // data_o keeps the last launched byte; only reset clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_data  <= w_head;
            r_valid <= 1'b1;
            r_cnt   <= 8'(GAP);
            r_state <= ST_GAP;
          end else begin
            r_valid <= 1'b0;
          end
        end
        ST_GAP: begin
          r_valid <= 1'b0;
          // cnt<=1 also covers a counter that somehow reached 0, so the FSM
          // can never get stuck in GAP.
          if (r_cnt > 8'd1) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready_o    = !w_full;
  assign data_o     = r_data;
  assign valid_o    = r_valid;
  assign level_o    = r_level;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_cdc_send_pacer.sv
// -----------------------------------------------------------------------------
// tb_cdc_send_pacer
//
// Self-checking bench for cdc_send_pacer. A behavioural model (queue of bytes,
// edge index of the last launch, sticky flag) predicts every output after
// every clock edge; directed scenarios add explicit expectations on top.
// -----------------------------------------------------------------------------
module tb_cdc_send_pacer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int GAP    = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk_i;
  logic              resetn_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic              clr_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic [LW-1:0]     level_o;
  logic              overflow_o;

  cdc_send_pacer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .GAP    (GAP)
  ) dut (
    .clk_i      (clk_i),
    .resetn_i   (resetn_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .clr_i      (clr_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Counters and reference model state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_data;
  bit                m_valid;
  bit                m_ovf;
  int                m_edge;
  int                m_last;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_last  = m_edge - 1000;
  endtask

  task automatic compare_all(input string ctx);
    check_eq({ctx, ".valid"},    32'(valid_o),    32'(m_valid));
    check_eq({ctx, ".data"},     32'(data_o),     32'(m_data));
    check_eq({ctx, ".level"},    32'(level_o),    32'(m_q.size()));
    check_eq({ctx, ".ready"},    32'(ready_o),    32'(m_q.size() < DEPTH));
    check_eq({ctx, ".overflow"}, 32'(overflow_o), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then compare.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit c);
    bit launch;
    bit full_pre;
    valid_i = v;
    data_i  = d;
    clr_i   = c;
    @(posedge clk_i);
    full_pre = (m_q.size() == DEPTH);
    launch   = (m_q.size() > 0) && ((m_edge - m_last) >= GAP + 1);
    if (launch) begin
      m_data = m_q.pop_front();
      m_last = m_edge;
    end
    if (v && !full_pre) m_q.push_back(d);
    if (v && full_pre)  m_ovf = 1'b1;
    else if (c)         m_ovf = 1'b0;
    m_valid = launch;
    m_edge++;
    #1;
    compare_all("cyc");
    if (valid_o) $display("launch edge=%0d data=0x%02h level=%0d", m_edge - 1, data_o, level_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Assert reset away from a clock edge, check outputs collapse at once,
  // hold it with toggling inputs, then release away from an edge.
  task automatic apply_reset(input int cycles);
    resetn_i = 1'b0;
    #1;
    model_reset();
    compare_all("rst.async");
    for (int i = 0; i < cycles; i++) begin
      valid_i = 1'($urandom);
      data_i  = DATA_W'($urandom);
      clr_i   = 1'($urandom);
      @(posedge clk_i);
      #1;
      compare_all("rst.hold");
    end
    #2;
    valid_i  = 1'b0;
    clr_i    = 1'b0;
    resetn_i = 1'b1;
    $display("reset released t=%0t", $time);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [DATA_W-1:0] got[$];
    int                p;

    m_edge   = 0;
    resetn_i = 1'b0;
    valid_i  = 1'b0;
    clr_i    = 1'b0;
    data_i   = '0;

    // Power-on reset with random inputs toggling.
    apply_reset(4);
    check_eq("rst.valid", 32'(valid_o),    32'd0);
    check_eq("rst.data",  32'(data_o),     32'h00);
    check_eq("rst.level", 32'(level_o),    32'd0);
    check_eq("rst.ready", 32'(ready_o),    32'd1);
    check_eq("rst.ovf",   32'(overflow_o), 32'd0);

    // Single byte: pushed at edge k, launched at k+1, one-cycle pulse.
    idle(2);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_eq("single.valid", 32'(valid_o), 32'd1);
    check_eq("single.data",  32'(data_o),  32'hA5);
    step(1'b0, 8'h00, 1'b0);
    check_eq("single.valid_low", 32'(valid_o), 32'd0);
    check_eq("single.hold",      32'(data_o),  32'hA5);
    check_eq("single.level",     32'(level_o), 32'd0);
    idle(8);

    // Paced burst: 0x01..0x04 at edges 0..3, pulses after edges 1,6,11,16.
    for (int rel = 0; rel <= 20; rel++) begin
      bit pulse;
      step(rel < 4, DATA_W'(rel + 1), 1'b0);
      pulse = (rel >= 1) && (rel <= 16) && ((rel - 1) % 5 == 0);
      check_eq("burst.valid", 32'(valid_o), 32'(pulse));
      if (pulse) check_eq("burst.data", 32'(data_o), 32'((rel - 1) / 5 + 1));
      check_eq("burst.ovf", 32'(overflow_o), 32'd0);
    end
    idle(4);

    // Overflow: 0x11..0x16 at edges 0..5; 0x16 is dropped.
    got.delete();
    for (int rel = 0; rel <= 30; rel++) begin
      step(rel < 6, DATA_W'(8'h11 + rel), 1'b0);
      if (valid_o) got.push_back(data_o);
      if (rel == 4) begin
        check_eq("ovf.level_full", 32'(level_o), 32'd4);
        check_eq("ovf.ready_low",  32'(ready_o), 32'd0);
      end
      if (rel == 5) check_eq("ovf.flag", 32'(overflow_o), 32'd1);
    end
    check_eq("ovf.count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++) begin
      check_eq("ovf.order", 32'(got[i]), 32'(8'h11 + i));
    end

    // Clear priority: clr alone clears, clr with a drop leaves the flag set.
    step(1'b0, 8'h00, 1'b1);
    check_eq("clr.alone", 32'(overflow_o), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    idle(6);
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'h40 + i), 1'b0);
    check_eq("clr.full", 32'(ready_o), 32'd0);
    step(1'b1, 8'h4F, 1'b1);
    check_eq("clr.drop_wins", 32'(overflow_o), 32'd1);
    idle(30);
    step(1'b0, 8'h00, 1'b1);
    check_eq("clr.final", 32'(overflow_o), 32'd0);
    idle(2);

    // Reset mid-burst: 3 bytes queued, FSM in GAP.
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(8'h61 + i), 1'b0);
    check_eq("midrst.level_pre", 32'(level_o), 32'd3);
    apply_reset(2);
    check_eq("midrst.valid", 32'(valid_o), 32'd0);
    check_eq("midrst.level", 32'(level_o), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h00, 1'b0);
      check_eq("midrst.no_stale", 32'(valid_o), 32'd0);
    end

    // Randomized traffic with varying load, occasional clears and resets.
    p = 50;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      if (cyc % 100 == 0) p = $urandom_range(5, 95);
      if (cyc % 700 == 350) apply_reset($urandom_range(1, 3));
      step($urandom_range(0, 99) < p, DATA_W'($urandom),
           $urandom_range(0, 24) == 0);
    end
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdc_send_pacer.md
# cdc_send_pacer

Send-domain pacing stage that sits directly upstream of the clock-domain-crossing data path. It buffers incoming bytes in a small FIFO. It re-emits them as single-cycle `valid_o` pulses separated by at least `GAP` idle cycles, so the pulse-based crossing into the receive domain never sees two pulses closer than it can synchronise. It also flags bytes dropped on a full buffer.

## Interface
Parameters:
- `DATA_W`, 8, byte width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `GAP`, 4, minimum idle cycles between `valid_o` pulses; legal range 1..255.

Ports:
- `clk_i`  in  1  send-domain clock; the only clock.
- `resetn_i`  in  1  asynchronous, active-low reset.
- `data_i`  in  DATA_W  byte from the producer.
- `valid_i`  in  1  byte present; sampled on rising `clk_i`.
- `ready_o`  out  1  `!full`, combinational from the FIFO level.
- `clr_i`  in  1  single-cycle pulse; clears `overflow_o`.
- `data_o`  out  DATA_W  registered byte toward the CDC stage.
- `valid_o`  out  1  registered single-cycle launch pulse.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow_o`  out  1  sticky: a byte was dropped.

## Operation
- Push: at an edge where `valid_i=1` and `ready_o=1`, write `data_i` at the tail.
- Drop: at an edge where `valid_i=1` and `ready_o=0`, discard the byte and set `overflow_o`.
- `ready_o` is evaluated on the level before that edge. A push on a full FIFO is dropped even if a pop occurs at the same edge.
- Push and pop at the same edge with level < DEPTH: level unchanged, both take effect.
- FSM with two states, IDLE and GAP, plus an 8-bit down-counter `cnt`.
  - IDLE, level>0: pop head into `data_o`, `valid_o<=1`, `cnt<=GAP`, go to GAP.
  - IDLE, level=0: `valid_o<=0`, stay in IDLE.
  - GAP: `valid_o<=0`. If `cnt>1`, decrement `cnt`. If `cnt==1`, go to IDLE.
- `data_o` holds the last launched byte between pulses and is never cleared except by reset.
- Bytes leave in strict FIFO order.
- `overflow_o`: set by a drop, cleared by `clr_i`. If `clr_i` and a drop occur at the same edge, set wins and `overflow_o` stays 1.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `level_o` spans 0..DEPTH.

## Timing
- Reset values, applied asynchronously:
  - `data_o=0`, `valid_o=0`, `overflow_o=0`, `level_o=0`, `ready_o=1`.
  - FSM in IDLE, pointers 0, `cnt=0`.
- Reset mid-operation flushes all queued bytes. `valid_o` drops immediately without waiting for a clock edge. No stale byte is emitted after release.
- Latency into an empty, idle block:
  - byte pushed at edge k;
  - launched at edge k+1;
  - `valid_o` high for the cycle after edge k+1 only.
- Pulse spacing:
  - launch at edge e;
  - `valid_o` low after edges e+1 .. e+GAP (GAP idle cycles);
  - earliest next launch at edge e+GAP+1, giving a period of GAP+1 cycles.
- `valid_o` is never high on two consecutive cycles.

## Test plan
- Reset check: hold `resetn_i=0` with random inputs toggling. Required: `valid_o=0`, `data_o=0x00`, `level_o=0`, `ready_o=1`, `overflow_o=0`.
- Single byte: push 0xA5 at edge k. Required: `valid_o` high for exactly one cycle after edge k+1 with `data_o=0xA5`; `data_o` stays 0xA5 afterwards; `level_o` returns to 0.
- Paced burst, GAP=4: push 0x01..0x04 at edges 0..3. Required:
  - pulses after edges 1, 6, 11, 16, carrying 0x01, 0x02, 0x03, 0x04 in order;
  - `valid_o` low on all other cycles;
  - `overflow_o` stays 0.
- Overflow, DEPTH=4, GAP=4: push 0x11..0x16 at edges 0..5. Required:
  - `level_o` reaches 4 after edge 4;
  - `ready_o=0` at edge 5, 0x16 dropped, `overflow_o=1`;
  - 0x11..0x15 delivered in order, 0x16 never appears.
- Clear priority: with `overflow_o=1`, pulse `clr_i` alone and expect `overflow_o=0`. Then fill to full and pulse `clr_i` at the same edge as a dropped push; expect `overflow_o=1`.
- Reset mid-burst: with 3 bytes queued and the FSM in GAP, assert `resetn_i=0` between edges. Required: `valid_o` and `level_o` go to 0 immediately; after release, no pulse until a new push.
